// File: rtl/pattern_sequencer_if.sv
// Pattern sequencer pin bundle.
//   load, run, din : controls driven toward the sequencer
//   o, step, busy  : registered playback outputs
// The master modport drives the controls and the slave modport is the sequencer side.
interface pattern_sequencer_if #(
    parameter int SW = 3
);
    logic          load;
    logic          run;
    logic [3:0]    din;
    logic [3:0]    o;
    logic [SW-1:0] step;
    logic          busy;

    modport master (output load, run, din, input  o, step, busy);
    modport slave  (input  load, run, din, output o, step, busy);
endinterface

// File: rtl/pattern_sequencer.sv
// Programmable step sequencer for the tile's output nibble.
// Nibbles are loaded one per cycle into a DEPTH-slot store. The stored pattern
// then plays back in a loop, and each slot is held for DIV cycles.
//   clk       : tile clock, rising edge
//   rst       : asynchronous, active-high reset
//   bus.load  : write din into the store (IDLE), or clear the pattern (PAUSE, run=0)
//   bus.run   : play (1) / pause (0)
//   bus.din   : nibble to store
//   bus.o     : current pattern nibble
//   bus.step  : slot index currently shown on o
//   bus.busy  : state != IDLE
module pattern_sequencer #(
    parameter int DEPTH = 8,
    parameter int DIV   = 4,
    parameter int SW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    pattern_sequencer_if.slave      bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW = SW + 1;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    mem [DEPTH];
    logic [3:0]    o;
    logic [SW-1:0] rp, wp, rp_nxt;
    logic [LW-1:0] len;
    logic [PW-1:0] pre;
    logic          busy;

    logic do_write, do_start, do_adv, do_cnt, do_clear;
    logic tick;

    // rp is the displayed slot, so it drives step directly.
    assign bus.o    = o;
    assign bus.step = rp;
    assign bus.busy = busy;

    assign rp_nxt = ({1'b0, rp} == len - 1'b1) ? '0 : rp + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        do_start  = 1'b0;
        do_clear  = 1'b0;
        tick      = 1'b0;
        case (state)
            IDLE: begin
                // LOAD has priority over RUN. An empty store never starts playback.
                if (bus.load) begin
                    do_write = 1'b1;
                end else if (bus.run && len != '0) begin
                    do_start  = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (!bus.run) state_nxt = PAUSE;
                else          tick      = 1'b1;
            end
            PAUSE: begin
                // The resume edge counts as a play edge, so the dwell time
                // already spent before the pause is preserved exactly.
                if (bus.run) begin
                    state_nxt = PLAY;
                    tick      = 1'b1;
                end else if (bus.load) begin
                    do_clear  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign do_adv = tick && (pre == PW'(DIV - 1));
    assign do_cnt = tick && !do_adv;

    // The store has no reset. Slots at or beyond len are never read.
    always_ff @(posedge clk) begin
        if (do_write) mem[wp] <= bus.din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o   <= '0;
            rp  <= '0;
            wp  <= '0;
            len <= '0;
            pre <= '0;
        end else begin
            if (do_write) begin
                wp <= wp + 1'b1;
                if (len != LW'(DEPTH)) len <= len + 1'b1;
            end
            if (do_start) begin
                rp  <= '0;
                o   <= mem[0];
                pre <= '0;
            end
            if (do_adv) begin
                rp  <= rp_nxt;
                o   <= mem[rp_nxt];
                pre <= '0;
            end
            if (do_cnt) pre <= pre + 1'b1;
            if (do_clear) begin
                wp  <= '0;
                len <= '0;
                o   <= '0;
                rp  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;
    localparam int DEPTH = 8;
    localparam int DIV   = 4;
    localparam int SW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_sequencer_if #(.SW(SW)) bus ();

    pattern_sequencer #(.DEPTH(DEPTH), .DIV(DIV), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Reference model. Playback position is the count of play edges since start.
    // The shown slot is (ticks / DIV) % len.
    int         m_mode;    // 0 idle, 1 play, 2 pause
    int         m_writes;  // writes since the last clear/reset
    int         m_ticks;
    logic [3:0] m_mem [DEPTH];

    function automatic int m_len();
        return (m_writes > DEPTH) ? DEPTH : m_writes;
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_writes = 0;
        m_ticks  = 0;
    endtask

    task automatic model_edge(input bit ld, input bit rn, input logic [3:0] d);
        case (m_mode)
            0: if (ld) begin
                   m_mem[m_writes % DEPTH] = d;
                   m_writes++;
               end else if (rn && m_len() > 0) begin
                   m_mode  = 1;
                   m_ticks = 0;
               end
            1: if (!rn) m_mode = 2;
               else     m_ticks++;
            default: if (rn) begin
                         m_mode = 1;
                         m_ticks++;
                     end else if (ld) begin
                         m_writes = 0;
                         m_mode   = 0;
                     end
        endcase
    endtask

    task automatic check_out(input string tag);
        int idx;
        idx = (m_mode == 0) ? 0 : (m_ticks / DIV) % m_len();
        chk({tag, ".o"},    32'(bus.o),    (m_mode == 0) ? 32'd0 : 32'(m_mem[idx]));
        chk({tag, ".step"}, 32'(bus.step), 32'(idx));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_mode != 0));
    endtask

    task automatic cyc(input bit ld, input bit rn, input logic [3:0] d, input string tag);
        bus.load = ld;
        bus.run  = rn;
        bus.din  = d;
        @(posedge clk);
        model_edge(ld, rn, d);
        #1;
        check_out(tag);
    endtask

    // Called 1ns after an edge. Reset pulses and is released before the next edge.
    task automatic areset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_out(tag);
        rst = 1'b0;
    endtask

    initial begin
        bus.load = 1'b0;
        bus.run  = 1'b0;
        bus.din  = 4'h0;
        model_reset();
        #2;
        check_out("rst");
        rst = 1'b0;

        // 1: three-slot loop
        cyc(1, 0, 4'hA, "t1ld");
        cyc(1, 0, 4'h5, "t1ld");
        cyc(1, 0, 4'hF, "t1ld");
        cyc(0, 1, 4'h0, "t1run");
        chk("t1.first", 32'(bus.o), 32'hA);
        for (int i = 0; i < 14; i++) cyc(0, 1, 4'h0, "t1run");

        // 5: pause then clear, and a later RUN does not start
        cyc(0, 0, 4'h0, "t5pause");
        cyc(1, 0, 4'h3, "t5clr");
        chk("t5.busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'h0, "t5run");

        // 2: nine writes wrap onto slot 0
        for (int i = 1; i <= 9; i++) cyc(1, 0, 4'(i), "t2ld");
        cyc(0, 1, 4'h0, "t2run");
        chk("t2.slot0", 32'(bus.o), 32'h9);
        for (int i = 0; i < DIV; i++) cyc(0, 1, 4'h0, "t2run");
        chk("t2.slot1", 32'(bus.o), 32'h2);
        for (int i = 0; i < 36; i++) cyc(0, 1, 4'h0, "t2run");
        cyc(0, 0, 4'h0, "t2pause");
        cyc(1, 0, 4'h0, "t2clr");

        // 3: mid-step pause preserves the remaining dwell
        for (int i = 0; i < 4; i++) cyc(1, 0, 4'(i + 4), "t3ld");
        cyc(0, 1, 4'h0, "t3run");
        for (int i = 0; i < DIV + 1; i++) cyc(0, 1, 4'h0, "t3run");
        for (int i = 0; i < 10; i++) cyc(0, 0, 4'h0, "t3hold");
        chk("t3.frozen", 32'(bus.step), 32'd1);
        cyc(0, 1, 4'h0, "t3res");
        chk("t3.rem1", 32'(bus.step), 32'd1);
        cyc(0, 1, 4'h0, "t3res");
        chk("t3.rem2", 32'(bus.step), 32'd1);
        cyc(0, 1, 4'h0, "t3res");
        chk("t3.next", 32'(bus.step), 32'd2);
        cyc(0, 0, 4'h0, "t3pause");
        cyc(1, 0, 4'h0, "t3clr");

        // 4: empty RUN, then LOAD+RUN writes only
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'h0, "t4empty");
        cyc(1, 1, 4'h7, "t4both");
        chk("t4.nostart", 32'(bus.busy), 32'd0);
        cyc(0, 1, 4'h0, "t4run");
        chk("t4.start", 32'(bus.o), 32'h7);

        // 6: asynchronous reset mid-play
        for (int i = 0; i < 6; i++) cyc(0, 1, 4'h0, "t6run");
        areset("t6arst");
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'h0, "t6idle");

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) areset("rnd_arst");
            else cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                     4'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
